// File: rtl/video_rx_monitor_if.sv
// Video bus as driven by the frame generator: syncs, active-video qualifier,
// link mode and two RGB pixel lanes.
interface video_rx_monitor_if;
  logic       link;
  logic       vsync;
  logic       hsync;
  logic       data_valid;
  logic [7:0] data0_r;
  logic [7:0] data0_g;
  logic [7:0] data0_b;
  logic [7:0] data1_r;
  logic [7:0] data1_g;
  logic [7:0] data1_b;

  modport master (
    output link, vsync, hsync, data_valid,
    output data0_r, data0_g, data0_b, data1_r, data1_g, data1_b
  );

  modport slave (
    input link, vsync, hsync, data_valid,
    input data0_r, data0_g, data0_b, data1_r, data1_g, data1_b
  );
endinterface

// File: rtl/video_rx_monitor.sv
// Receive-side video checker: measures per-frame geometry, timing and pixel
// checksum, flags size/line errors and reports timing lock at each vsync.
module video_rx_monitor #(
  parameter int unsigned HOR_RESOLUTION = 1366,
  parameter int unsigned VER_RESOLUTION = 768,
  parameter string       HSYNC_POL      = "NEGATIVE",
  parameter string       VSYNC_POL      = "NEGATIVE",
  parameter int unsigned CNT_W          = 13
) (
  input  logic                     pixel_clock_i,
  input  logic                     reset_i,
  video_rx_monitor_if.slave        vid,
  output logic                     frame_done_o,
  output logic [CNT_W-1:0]         h_active_o,
  output logic [CNT_W-1:0]         v_active_o,
  output logic [CNT_W-1:0]         h_total_o,
  output logic [CNT_W-1:0]         v_total_o,
  output logic [31:0]              checksum_o,
  output logic [15:0]              frame_cnt_o,
  output logic                     size_err_o,
  output logic                     line_err_o,
  output logic                     locked_o
);

  localparam bit                HS_POS  = (HSYNC_POL == "POSITIVE");
  localparam bit                VS_POS  = (VSYNC_POL == "POSITIVE");
  localparam int unsigned       CW1     = CNT_W + 1;
  localparam logic [CNT_W-1:0]  CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  HOR_EXP = CNT_W'(HOR_RESOLUTION);
  localparam logic [CNT_W-1:0]  VER_EXP = CNT_W'(VER_RESOLUTION);

  typedef enum logic {WAIT_VS, FRAME} state_t;

  state_t state, state_nx;

  // Saturating add; MSB of the result flags that the counter hit its ceiling.
  function automatic logic [CNT_W:0] sat_add(input logic [CNT_W-1:0] a, input logic [1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + CW1'(b);
    if (s >= CW1'(CNT_MAX)) return {1'b1, CNT_MAX};
    return s;
  endfunction

  logic        vs_q, hs_q, dv_q, link_q;
  logic        vs_d, hs_d, dv_d;
  logic [23:0] px0_q, px1_q;
  logic        vs_rise, hs_rise, line_end;

  logic [CNT_W-1:0] pix_cnt, line_cnt, ref_len, htot_ref, vtot, hcyc;
  logic             htot_have, hs_seen, line_err, ovf;
  logic [31:0]      csum;

  logic [CNT_W-1:0] prev_h, prev_v, prev_ht, prev_vt;
  logic             prev_ok;

  logic [CNT_W-1:0] pix_nx, line_nx, ref_nx, href_nx, vtot_nx, hcyc_nx;
  logic             hhave_nx, hseen_nx, lerr_nx, ovf_nx;
  logic [31:0]      csum_nx;
  logic [CNT_W:0]   pix_sum, line_sum, vtot_sum, hcyc_sum, close_sum;
  logic [CNT_W-1:0] pub_ref, pub_lines;
  logic             pub_lerr, pub_ovf, pub_size, pub_match;

  // Input stage: syncs normalised to active-high.
  always_ff @(posedge pixel_clock_i) begin
    if (reset_i) begin
      vs_q   <= 1'b0;
      hs_q   <= 1'b0;
      dv_q   <= 1'b0;
      link_q <= 1'b0;
      vs_d   <= 1'b0;
      hs_d   <= 1'b0;
      dv_d   <= 1'b0;
      px0_q  <= '0;
      px1_q  <= '0;
    end else begin
      vs_q   <= VS_POS ? vid.vsync : ~vid.vsync;
      hs_q   <= HS_POS ? vid.hsync : ~vid.hsync;
      dv_q   <= vid.data_valid;
      link_q <= vid.link;
      vs_d   <= vs_q;
      hs_d   <= hs_q;
      dv_d   <= dv_q;
      px0_q  <= {vid.data0_r, vid.data0_g, vid.data0_b};
      px1_q  <= {vid.data1_r, vid.data1_g, vid.data1_b};
    end
  end

  assign vs_rise  = vs_q & ~vs_d;
  assign hs_rise  = hs_q & ~hs_d;
  assign line_end = dv_d & ~dv_q;

  always_ff @(posedge pixel_clock_i) begin
    if (reset_i) state <= WAIT_VS;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    pix_nx    = pix_cnt;
    line_nx   = line_cnt;
    ref_nx    = ref_len;
    href_nx   = htot_ref;
    hhave_nx  = htot_have;
    vtot_nx   = vtot;
    csum_nx   = csum;
    lerr_nx   = line_err;
    ovf_nx    = ovf;
    hcyc_nx   = hcyc;
    hseen_nx  = hs_seen;
    pix_sum   = '0;
    line_sum  = '0;
    vtot_sum  = '0;
    hcyc_sum  = '0;
    close_sum = '0;

    if (dv_q) begin
      pix_sum = sat_add(pix_cnt, link_q ? 2'd2 : 2'd1);
      pix_nx  = pix_sum[CNT_W-1:0];
      ovf_nx  = ovf_nx | pix_sum[CNT_W];
      csum_nx = csum + 32'(px0_q) + (link_q ? 32'(px1_q) : 32'd0);
    end

    if (line_end) begin
      line_sum = sat_add(line_cnt, 2'd1);
      line_nx  = line_sum[CNT_W-1:0];
      ovf_nx   = ovf_nx | line_sum[CNT_W];
      if (line_cnt == '0)          ref_nx  = pix_cnt;
      else if (pix_cnt != ref_len) lerr_nx = 1'b1;
      pix_nx = '0;
    end

    // Line period is measured rise-to-rise and may span a vsync boundary.
    if (hs_rise) begin
      vtot_sum = sat_add(vtot, 2'd1);
      vtot_nx  = vtot_sum[CNT_W-1:0];
      ovf_nx   = ovf_nx | vtot_sum[CNT_W];
      hcyc_nx  = CNT_W'(1);
      hseen_nx = 1'b1;
      if (hs_seen) begin
        if (hcyc == CNT_MAX) ovf_nx = 1'b1;
        if (!htot_have) begin
          href_nx  = hcyc;
          hhave_nx = 1'b1;
        end else if (hcyc != htot_ref) begin
          lerr_nx = 1'b1;
        end
      end
    end else begin
      hcyc_sum = sat_add(hcyc, 2'd1);
      hcyc_nx  = hcyc_sum[CNT_W-1:0];
    end

    // A line still open at vsync is closed into the finishing frame as an error.
    pub_ref   = ref_nx;
    pub_lines = line_nx;
    pub_lerr  = lerr_nx;
    pub_ovf   = ovf_nx;
    if (dv_q) begin
      close_sum = sat_add(line_nx, 2'd1);
      pub_lines = close_sum[CNT_W-1:0];
      pub_ovf   = pub_ovf | close_sum[CNT_W];
      if (line_nx == '0) pub_ref = pix_nx;
      pub_lerr = 1'b1;
    end
    pub_size  = (pub_ref != HOR_EXP) | (pub_lines != VER_EXP) | pub_ovf;
    pub_match = prev_ok & (pub_ref == prev_h) & (pub_lines == prev_v) &
                (href_nx == prev_ht) & (vtot_nx == prev_vt);

    case (state)
      WAIT_VS: if (vs_rise) state_nx = FRAME;
      FRAME:   state_nx = FRAME;
      default: state_nx = WAIT_VS;
    endcase
  end

  always_ff @(posedge pixel_clock_i) begin
    if (reset_i) begin
      pix_cnt      <= '0;
      line_cnt     <= '0;
      ref_len      <= '0;
      htot_ref     <= '0;
      htot_have    <= 1'b0;
      vtot         <= '0;
      csum         <= '0;
      line_err     <= 1'b0;
      ovf          <= 1'b0;
      hcyc         <= '0;
      hs_seen      <= 1'b0;
      prev_h       <= '0;
      prev_v       <= '0;
      prev_ht      <= '0;
      prev_vt      <= '0;
      prev_ok      <= 1'b0;
      frame_done_o <= 1'b0;
      h_active_o   <= '0;
      v_active_o   <= '0;
      h_total_o    <= '0;
      v_total_o    <= '0;
      checksum_o   <= '0;
      frame_cnt_o  <= '0;
      size_err_o   <= 1'b0;
      line_err_o   <= 1'b0;
      locked_o     <= 1'b0;
    end else begin
      frame_done_o <= 1'b0;
      hcyc         <= hcyc_nx;
      hs_seen      <= hseen_nx;

      if (state == FRAME && !vs_rise) begin
        pix_cnt   <= pix_nx;
        line_cnt  <= line_nx;
        ref_len   <= ref_nx;
        htot_ref  <= href_nx;
        htot_have <= hhave_nx;
        vtot      <= vtot_nx;
        csum      <= csum_nx;
        line_err  <= lerr_nx;
        ovf       <= ovf_nx;
      end else begin
        pix_cnt   <= '0;
        line_cnt  <= '0;
        ref_len   <= '0;
        htot_ref  <= '0;
        htot_have <= 1'b0;
        vtot      <= '0;
        csum      <= '0;
        line_err  <= 1'b0;
        ovf       <= 1'b0;
      end

      if (state == FRAME && vs_rise) begin
        frame_done_o <= 1'b1;
        h_active_o   <= pub_ref;
        v_active_o   <= pub_lines;
        h_total_o    <= href_nx;
        v_total_o    <= vtot_nx;
        checksum_o   <= csum_nx;
        frame_cnt_o  <= frame_cnt_o + 16'd1;
        size_err_o   <= pub_size;
        line_err_o   <= pub_lerr;
        locked_o     <= pub_match & ~pub_lerr & ~pub_size;
        prev_h       <= pub_ref;
        prev_v       <= pub_lines;
        prev_ht      <= href_nx;
        prev_vt      <= vtot_nx;
        prev_ok      <= ~pub_lerr & ~pub_size;
      end
    end
  end

endmodule

// File: tb/tb_video_rx_monitor.sv
// Directed bench for video_rx_monitor: negative-sync and positive-sync
// instances see the same 24x8-cycle frames (16x4 active) with inverted syncs.
module tb_video_rx_monitor;

  localparam int unsigned CW = 13;

  logic clk;
  logic rst;

  video_rx_monitor_if bus_n ();
  video_rx_monitor_if bus_p ();

  assign bus_p.vsync      = ~bus_n.vsync;
  assign bus_p.hsync      = ~bus_n.hsync;
  assign bus_p.data_valid = bus_n.data_valid;
  assign bus_p.link       = bus_n.link;
  assign bus_p.data0_r    = bus_n.data0_r;
  assign bus_p.data0_g    = bus_n.data0_g;
  assign bus_p.data0_b    = bus_n.data0_b;
  assign bus_p.data1_r    = bus_n.data1_r;
  assign bus_p.data1_g    = bus_n.data1_g;
  assign bus_p.data1_b    = bus_n.data1_b;

  logic          n_done, n_se, n_le, n_lk;
  logic [CW-1:0] n_h, n_v, n_ht, n_vt;
  logic [31:0]   n_cs;
  logic [15:0]   n_fc;
  logic          p_done, p_se, p_le, p_lk;
  logic [CW-1:0] p_h, p_v, p_ht, p_vt;
  logic [31:0]   p_cs;
  logic [15:0]   p_fc;

  video_rx_monitor #(
    .HOR_RESOLUTION(16), .VER_RESOLUTION(4),
    .HSYNC_POL("NEGATIVE"), .VSYNC_POL("NEGATIVE"), .CNT_W(CW)
  ) dut_n (
    .pixel_clock_i(clk), .reset_i(rst), .vid(bus_n),
    .frame_done_o(n_done), .h_active_o(n_h), .v_active_o(n_v),
    .h_total_o(n_ht), .v_total_o(n_vt), .checksum_o(n_cs),
    .frame_cnt_o(n_fc), .size_err_o(n_se), .line_err_o(n_le), .locked_o(n_lk)
  );

  video_rx_monitor #(
    .HOR_RESOLUTION(16), .VER_RESOLUTION(4),
    .HSYNC_POL("POSITIVE"), .VSYNC_POL("POSITIVE"), .CNT_W(CW)
  ) dut_p (
    .pixel_clock_i(clk), .reset_i(rst), .vid(bus_p),
    .frame_done_o(p_done), .h_active_o(p_h), .v_active_o(p_v),
    .h_total_o(p_ht), .v_total_o(p_vt), .checksum_o(p_cs),
    .frame_cnt_o(p_fc), .size_err_o(p_se), .line_err_o(p_le), .locked_o(p_lk)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Results latched whenever frame_done pulses
  int          n_done_cnt = 0;
  int          p_done_cnt = 0;
  int          s_h, s_v, s_ht, s_vt, s_fc;
  logic [31:0] s_cs;
  logic        s_se, s_le, s_lk;
  int          q_h, q_v, q_ht, q_vt, q_fc;
  logic [31:0] q_cs;
  logic        q_se, q_le, q_lk;

  always @(negedge clk) begin
    if (n_done === 1'b1) begin
      n_done_cnt++;
      s_h = int'(n_h); s_v = int'(n_v); s_ht = int'(n_ht); s_vt = int'(n_vt);
      s_fc = int'(n_fc); s_cs = n_cs; s_se = n_se; s_le = n_le; s_lk = n_lk;
    end
    if (p_done === 1'b1) begin
      p_done_cnt++;
      q_h = int'(p_h); q_v = int'(p_v); q_ht = int'(p_ht); q_vt = int'(p_vt);
      q_fc = int'(p_fc); q_cs = p_cs; q_se = p_se; q_le = p_le; q_lk = p_lk;
    end
  end

  // Outputs seen one cycle after a mid-frame reset
  logic        r_geo, r_flags;
  logic [31:0] r_cs;
  logic [15:0] r_fc;

  // One frame: 8 lines x 24 cycles, hsync 2 cycles, vsync 3 cycles on line 0,
  // active lines 2..5 with ncyc valid cycles starting at cycle 4.
  task automatic send_frame(input int ncyc, input bit lk, input int short_line, input int rst_at);
    int len;
    for (int l = 0; l < 8; l++) begin
      for (int c = 0; c < 24; c++) begin
        @(posedge clk); #1;
        if (rst_at >= 0 && l * 24 + c == rst_at + 1) begin
          r_geo   = |{n_h, n_v, n_ht, n_vt};
          r_flags = |{n_done, n_se, n_le, n_lk};
          r_cs    = n_cs;
          r_fc    = n_fc;
          rst     = 1'b0;
        end
        len = (l - 2 == short_line) ? ncyc - 1 : ncyc;
        bus_n.vsync      = !(l == 0 && c < 3);
        bus_n.hsync      = !(c < 2);
        bus_n.data_valid = (l >= 2 && l < 6 && c >= 4 && c < 4 + len);
        bus_n.link       = lk;
        if (rst_at >= 0 && l * 24 + c == rst_at) rst = 1'b1;
      end
    end
  endtask

  task automatic test_reset;
    checks++; if (n_h !== 0 || n_v !== 0) begin errors++; $display("FAIL reset_active: h=%0d v=%0d want 0 0", n_h, n_v); end
    checks++; if (n_ht !== 0 || n_vt !== 0) begin errors++; $display("FAIL reset_total: ht=%0d vt=%0d want 0 0", n_ht, n_vt); end
    checks++; if (n_cs !== 0 || n_fc !== 0) begin errors++; $display("FAIL reset_cs_fc: cs=%h fc=%0d want 0 0", n_cs, n_fc); end
    checks++; if ({n_done, n_se, n_le, n_lk} !== 4'b0) begin errors++; $display("FAIL reset_flags: got %b want 0000", {n_done, n_se, n_le, n_lk}); end
    checks++; if ({p_done, p_se, p_le, p_lk} !== 4'b0 || p_fc !== 0) begin errors++; $display("FAIL reset_pos: flags=%b fc=%0d want 0", {p_done, p_se, p_le, p_lk}, p_fc); end
  endtask

  task automatic test_basic;
    int d0;
    d0 = n_done_cnt;
    send_frame(16, 1'b0, -1, -1);
    checks++; if (n_done_cnt - d0 !== 0) begin errors++; $display("FAIL basic_first_vs: done pulses=%0d want 0", n_done_cnt - d0); end
    send_frame(16, 1'b0, -1, -1);
    checks++; if (n_done_cnt - d0 !== 1) begin errors++; $display("FAIL basic_done: pulses=%0d want 1", n_done_cnt - d0); end
    checks++; if (s_h !== 16 || s_v !== 4) begin errors++; $display("FAIL basic_active: h=%0d v=%0d want 16 4", s_h, s_v); end
    checks++; if (s_ht !== 24 || s_vt !== 8) begin errors++; $display("FAIL basic_total: ht=%0d vt=%0d want 24 8", s_ht, s_vt); end
    checks++; if (s_cs !== 32'h004080C0) begin errors++; $display("FAIL basic_checksum: got %h want 004080c0", s_cs); end
    checks++; if ({s_se, s_le, s_lk} !== 3'b000 || s_fc !== 1) begin errors++; $display("FAIL basic_status1: se/le/lk=%b fc=%0d want 000 1", {s_se, s_le, s_lk}, s_fc); end
    send_frame(16, 1'b0, -1, -1);
    checks++; if (s_lk !== 1'b1 || s_fc !== 2) begin errors++; $display("FAIL basic_lock: lk=%b fc=%0d want 1 2", s_lk, s_fc); end
    checks++; if (n_done_cnt - d0 !== 2) begin errors++; $display("FAIL basic_done_width: pulses=%0d want 2", n_done_cnt - d0); end
  endtask

  task automatic test_line_err;
    send_frame(16, 1'b0, 1, -1);
    checks++; if (s_lk !== 1'b1 || s_fc !== 3) begin errors++; $display("FAIL lerr_pre_lock: lk=%b fc=%0d want 1 3", s_lk, s_fc); end
    send_frame(16, 1'b0, -1, -1);
    checks++; if (s_le !== 1'b1 || s_lk !== 1'b0) begin errors++; $display("FAIL lerr_flag: le=%b lk=%b want 1 0", s_le, s_lk); end
    checks++; if (s_h !== 16 || s_v !== 4 || s_se !== 1'b0) begin errors++; $display("FAIL lerr_geom: h=%0d v=%0d se=%b want 16 4 0", s_h, s_v, s_se); end
    send_frame(16, 1'b0, -1, -1);
    checks++; if (s_le !== 1'b0 || s_lk !== 1'b0) begin errors++; $display("FAIL lerr_recover1: le=%b lk=%b want 0 0", s_le, s_lk); end
    send_frame(16, 1'b0, -1, -1);
    checks++; if (s_le !== 1'b0 || s_lk !== 1'b1 || s_fc !== 6) begin errors++; $display("FAIL lerr_relock: le=%b lk=%b fc=%0d want 0 1 6", s_le, s_lk, s_fc); end
  endtask

  task automatic test_dual_link;
    send_frame(8, 1'b1, -1, -1);
    send_frame(16, 1'b0, -1, -1);
    checks++; if (s_h !== 16 || s_v !== 4) begin errors++; $display("FAIL dual_active: h=%0d v=%0d want 16 4", s_h, s_v); end
    checks++; if (s_cs !== 32'h00A0E120) begin errors++; $display("FAIL dual_checksum: got %h want 00a0e120", s_cs); end
    checks++; if ({s_se, s_le, s_lk} !== 3'b001 || s_fc !== 8) begin errors++; $display("FAIL dual_status: se/le/lk=%b fc=%0d want 001 8", {s_se, s_le, s_lk}, s_fc); end
  endtask

  task automatic test_polarity;
    send_frame(16, 1'b0, -1, -1);
    checks++; if (q_h !== 16 || q_v !== 4 || q_ht !== 24 || q_vt !== 8) begin errors++; $display("FAIL pol_geom: h=%0d v=%0d ht=%0d vt=%0d want 16 4 24 8", q_h, q_v, q_ht, q_vt); end
    checks++; if (q_cs !== 32'h004080C0) begin errors++; $display("FAIL pol_checksum: got %h want 004080c0", q_cs); end
    checks++; if ({q_se, q_le, q_lk} !== 3'b001 || q_fc !== 9) begin errors++; $display("FAIL pol_status: se/le/lk=%b fc=%0d want 001 9", {q_se, q_le, q_lk}, q_fc); end
    checks++; if (p_done_cnt !== n_done_cnt || n_done_cnt !== 9) begin errors++; $display("FAIL pol_pulses: pos=%0d neg=%0d want 9 9", p_done_cnt, n_done_cnt); end
  endtask

  task automatic test_size_err;
    send_frame(20, 1'b0, -1, -1);
    send_frame(16, 1'b0, -1, -1);
    checks++; if (s_h !== 20 || s_se !== 1'b1) begin errors++; $display("FAIL size_flag: h=%0d se=%b want 20 1", s_h, s_se); end
    checks++; if (s_le !== 1'b0 || s_lk !== 1'b0 || s_fc !== 11) begin errors++; $display("FAIL size_status: le=%b lk=%b fc=%0d want 0 0 11", s_le, s_lk, s_fc); end
    checks++; if (s_cs !== 32'h0050A0F0) begin errors++; $display("FAIL size_checksum: got %h want 0050a0f0", s_cs); end
  endtask

  task automatic test_reset_mid;
    int d0;
    send_frame(16, 1'b0, -1, 50);
    checks++; if (r_geo !== 1'b0 || r_flags !== 1'b0) begin errors++; $display("FAIL rstmid_outputs: geo=%b flags=%b want 0 0", r_geo, r_flags); end
    checks++; if (r_cs !== 0 || r_fc !== 0) begin errors++; $display("FAIL rstmid_cs_fc: cs=%h fc=%0d want 0 0", r_cs, r_fc); end
    d0 = n_done_cnt;
    send_frame(16, 1'b0, -1, -1);
    checks++; if (n_done_cnt - d0 !== 0) begin errors++; $display("FAIL rstmid_no_done: pulses=%0d want 0", n_done_cnt - d0); end
    send_frame(16, 1'b0, -1, -1);
    checks++; if (n_done_cnt - d0 !== 1) begin errors++; $display("FAIL rstmid_done: pulses=%0d want 1", n_done_cnt - d0); end
    checks++; if (s_h !== 16 || s_v !== 4 || s_ht !== 24 || s_vt !== 8) begin errors++; $display("FAIL rstmid_geom: h=%0d v=%0d ht=%0d vt=%0d want 16 4 24 8", s_h, s_v, s_ht, s_vt); end
    checks++; if (s_fc !== 1 || {s_se, s_le, s_lk} !== 3'b000 || s_cs !== 32'h004080C0) begin errors++; $display("FAIL rstmid_status: fc=%0d se/le/lk=%b cs=%h want 1 000 004080c0", s_fc, {s_se, s_le, s_lk}, s_cs); end
  endtask

  initial begin
    rst              = 1'b1;
    bus_n.vsync      = 1'b1;
    bus_n.hsync      = 1'b1;
    bus_n.data_valid = 1'b0;
    bus_n.link       = 1'b0;
    bus_n.data0_r    = 8'd1;
    bus_n.data0_g    = 8'd2;
    bus_n.data0_b    = 8'd3;
    bus_n.data1_r    = 8'd4;
    bus_n.data1_g    = 8'd5;
    bus_n.data1_b    = 8'd6;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    test_reset();
    test_basic();
    test_line_err();
    test_dual_link();
    test_polarity();
    test_size_err();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/video_rx_monitor.md
# video_rx_monitor

Receive-side checker for the simulation video path: sits on the vsync/hsync/data_valid/RGB bus driven by the frame generator and measures, per frame, the active geometry, total timing, and a pixel checksum. It flags geometry mismatch and line-length inconsistency, and reports lock once the incoming timing is stable. Testbenches read its registered results at each frame boundary to self-check generated or processed video.

## Interface
Parameters:
- HOR_RESOLUTION, 1366, expected active pixels per line
- VER_RESOLUTION, 768, expected active lines per frame
- HSYNC_POL, "NEGATIVE", hsync polarity ("NEGATIVE"/"POSITIVE")
- VSYNC_POL, "NEGATIVE", vsync polarity ("NEGATIVE"/"POSITIVE")
- CNT_W, 13, width of all geometry counters/outputs

Ports:
- pixel_clock_i  in  1  single clock, all logic on rising edge
- reset_i  in  1  synchronous, active-high reset
- link_i  in  1  0 = single pixel per valid cycle, 1 = dual (data0+data1)
- vsync_i, hsync_i  in  1  sync inputs, polarity per parameters
- data_valid_i  in  1  active-video qualifier
- data0_r_i, data0_g_i, data0_b_i, data1_r_i, data1_g_i, data1_b_i  in  8 each  pixel data
- frame_done_o  out  1  one-cycle pulse, results below updated
- h_active_o, v_active_o, h_total_o, v_total_o  out  CNT_W  last frame measurements
- checksum_o  out  32  last frame pixel sum
- frame_cnt_o  out  16  completed frames, wraps
- size_err_o, line_err_o, locked_o  out  1  status for last frame

## Operation
- Input stage: all inputs registered once; syncs normalised to active-high internally. Edge detect on registered values.
- FSM: WAIT_VS -> FRAME. WAIT_VS: ignore traffic until first vsync rise, then FRAME with counters cleared, no frame_done. FRAME: each vsync rise closes frame (publish results, pulse frame_done_o), clears counters, stays in FRAME.
- pix_cnt: +1 per valid cycle (+2 if link_i=1). On data_valid fall: line ends; line_cnt +1; first line of frame latches ref_len; any later line with pix_cnt != ref_len sets sticky line_err; pix_cnt clears.
- htot: cycles between consecutive hsync rises; first measured value in frame is ref; any differing value sets line_err. v_total = hsync rises between vsync rises.
- checksum: per valid pixel add {r,g,b} zero-extended to 32 bits, mod 2^32; dual link adds data0 then data1 in same cycle.
- On publish: h_active_o=ref_len, v_active_o=line_cnt, h_total_o=htot ref, v_total_o, checksum_o, line_err_o; size_err_o = (h_active != HOR_RESOLUTION) | (v_active != VER_RESOLUTION) | any counter overflow; frame_cnt_o +1.
- locked_o: set at publish when this frame's h_active/v_active/h_total/v_total equal previous frame's and line_err=0 and size_err=0; cleared at publish otherwise.

## Timing
- Reset: all outputs 0, FSM WAIT_VS, previous-frame store cleared (first frame can never lock).
- Latency: vsync active first sampled at edge k (input reg); frame_done_o and all results update at edge k+1; frame_done_o high exactly one cycle.
- Outputs hold between publishes.
- Counters saturate at 2^CNT_W-1; saturation sets size_err for that frame.
- data_valid high at vsync rise: open line closed with current pix_cnt, counted in v_active, line_err set.
- data_valid and line end in the same cycle as vsync rise: line belongs to closing frame.
- hsync rise coincident with vsync rise: counts toward closing frame's v_total.
- link_i sampled every cycle; changing it mid-line yields mismatched lengths -> line_err.
- reset_i mid-frame: immediate return to reset state; next vsync rise only starts a frame.

## Test plan
- Single link, 16x4 active, h_total 24 cycles, v_total 8 lines -> at 2nd vsync frame_done=1, h_active=16, v_active=4, h_total=24, v_total=8, size_err=0 (params 16/4), locked=0; at 3rd vsync locked=1, frame_cnt=2.
- link_i=1, 8 valid cycles per line -> h_active=16, checksum counts 64 pixels.
- All pixels r=1,g=2,b=3, 64 pixels -> checksum_o=0x004080C0.
- Line 2 of a frame 15 pixels -> that frame line_err=1, locked 1->0; next clean frame line_err=0, locked stays 0, following clean frame locked=1.
- Both polarities "POSITIVE" with inverted stimulus -> identical results to negative case.
- reset_i pulsed mid-frame -> all outputs 0 next cycle; next vsync no frame_done; first frame_done at following vsync with correct values.
